dmem_host_seq: RTL and testbench

DMEM_HOST_SEQ -- requirements
Module: dmem_host_seq

---
 rtl/dmem_host_seq_pkg.sv | 14 +
 rtl/dmem_host_seq.sv | 109 ++++++++++
 tb/tb_dmem_host_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_host_seq_pkg.sv
// Shared types and default build constants for the host-to-dmem command sequencer.
package dmem_host_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int READ_LAT_DEFAULT = 2;
  localparam int ADDR_W_DEFAULT   = 8;

endpackage

// File: rtl/dmem_host_seq.sv
// Host command sequencer: takes one read/write command at a time, borrows the dmem
// port from the pipeline while it runs, and returns read data with a done pulse.
module dmem_host_seq
  import dmem_host_seq_pkg::*;
#(
  parameter int READ_LAT = READ_LAT_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              write_to_dmem,
  output logic              read_req_dmem,
  output logic [ADDR_W-1:0] addr_dmem_host,
  output logic [31:0]       data_dmem_host,
  input  logic [63:0]       dmem_out,
  output logic [63:0]       rdata,
  output logic              rdata_valid,
  output logic              cmd_done,
  output logic              pipe_stall
);

  localparam int CNT_W = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             is_read_reg;
  logic             accept;
  logic             rd_last;

  assign accept  = (state_reg == IDLE) && cmd_valid;
  assign rd_last = (state_reg == RD) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid) state_next = cmd_write ? WR : RD;
      WR:      state_next = DONE;
      RD:      if (rd_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address/data are only captured on acceptance, so host traffic during a
  // running command cannot disturb what dmem sees.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      is_read_reg    <= 1'b0;
      addr_dmem_host <= '0;
      data_dmem_host <= '0;
      rdata          <= '0;
    end else begin
      if (accept) begin
        addr_dmem_host <= cmd_addr;
        data_dmem_host <= cmd_wdata;
        is_read_reg    <= !cmd_write;
      end
      cnt_reg <= (state_reg == RD) ? cnt_reg + 1'b1 : '0;
      if (rd_last) begin
        rdata <= dmem_out;
      end
    end
  end

  // All outputs decode the state register only, keeping pipe_stall free of any
  // path from the host handshake.
  always_comb begin
    cmd_ready     = 1'b0;
    write_to_dmem = 1'b0;
    read_req_dmem = 1'b0;
    pipe_stall    = 1'b0;
    cmd_done      = 1'b0;
    rdata_valid   = 1'b0;
    case (state_reg)
      IDLE: cmd_ready = 1'b1;
      WR: begin
        write_to_dmem = 1'b1;
        pipe_stall    = 1'b1;
      end
      RD: begin
        read_req_dmem = 1'b1;
        pipe_stall    = 1'b1;
      end
      DONE: begin
        pipe_stall  = 1'b1;
        cmd_done    = 1'b1;
        rdata_valid = is_read_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_host_seq.sv
// Bench for dmem_host_seq: directed command table, hand-written corner sequences
// and a randomized run, all compared against a per-cycle transaction model.
module tb_dmem_host_seq;

  localparam int LAT = 2;
  localparam int AW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic          cmd_ready, write_to_dmem, read_req_dmem, rdata_valid, cmd_done, pipe_stall;
  logic [AW-1:0] addr_dmem_host;
  logic [31:0]   data_dmem_host;
  logic [63:0]   dmem_out, rdata;

  dmem_host_seq #(.READ_LAT(LAT), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .write_to_dmem(write_to_dmem), .read_req_dmem(read_req_dmem),
    .addr_dmem_host(addr_dmem_host), .data_dmem_host(data_dmem_host),
    .dmem_out(dmem_out), .rdata(rdata), .rdata_valid(rdata_valid),
    .cmd_done(cmd_done), .pipe_stall(pipe_stall)
  );

  // Second build with the shortest read latency.
  logic          c1_valid = 1'b0;
  logic          c1_write = 1'b0;
  logic [AW-1:0] c1_addr = '0;
  logic [31:0]   c1_wdata = '0;
  logic          c1_ready, c1_wr, c1_rd, c1_rv, c1_done, c1_stall;
  logic [AW-1:0] c1_addr_o;
  logic [31:0]   c1_data_o;
  logic [63:0]   c1_dmem_out, c1_rdata;

  dmem_host_seq #(.READ_LAT(1), .ADDR_W(AW)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_write(c1_write),
    .cmd_addr(c1_addr), .cmd_wdata(c1_wdata),
    .write_to_dmem(c1_wr), .read_req_dmem(c1_rd),
    .addr_dmem_host(c1_addr_o), .data_dmem_host(c1_data_o),
    .dmem_out(c1_dmem_out), .rdata(c1_rdata), .rdata_valid(c1_rv),
    .cmd_done(c1_done), .pipe_stall(c1_stall)
  );

  assign c1_dmem_out = c1_rd ? {32'h0, 24'hCAFE00, c1_addr_o} : 64'hBAD0_BAD0_BAD0_BAD0;

  // Untouched words read back a fixed address-derived pattern.
  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return {a, ~a, a ^ 8'h3C, 8'hA5};
  endfunction

  // dmem environment: valid data only on the last cycle of the requested latency,
  // random garbage otherwise so an early or late capture is visible.
  logic [31:0] env_mem [256];
  bit          env_written [256];
  int          rd_run = 0;
  logic [63:0] garbage = 64'h0123_4567_89AB_CDEF;

  always @(posedge clk) begin
    if (write_to_dmem) begin
      env_mem[addr_dmem_host]     <= data_dmem_host;
      env_written[addr_dmem_host] <= 1'b1;
    end
    rd_run  <= read_req_dmem ? rd_run + 1 : 0;
    garbage <= {$urandom, $urandom};
  end

  assign dmem_out = (read_req_dmem && rd_run == LAT - 1)
                    ? {32'h0, (env_written[addr_dmem_host] ? env_mem[addr_dmem_host]
                                                            : init_word(addr_dmem_host))}
                    : garbage;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Transaction model: an accepted command becomes a list of per-cycle phases.
  typedef struct packed {
    logic wr;
    logic rd;
    logic done;
    logic rv;
  } phase_t;

  phase_t        plan[$];
  logic [31:0]   model_mem [256];
  bit            model_written [256];
  logic [AW-1:0] exp_addr = '0;
  logic [31:0]   exp_data = '0;
  logic [63:0]   exp_rdata = '0;
  logic [63:0]   pend_rdata = '0;
  bit            armed = 1'b0;
  int            txn = 0;
  phase_t        cur;
  bit            idle;

  function automatic phase_t mk(input logic wr, input logic rd, input logic done, input logic rv);
    phase_t p;
    p.wr = wr; p.rd = rd; p.done = done; p.rv = rv;
    return p;
  endfunction

  always @(negedge clk) begin : model
    idle = (plan.size() == 0);
    cur  = idle ? mk(1'b0, 1'b0, 1'b0, 1'b0) : plan[0];
    if (armed) begin
      checks++;
      if ({cmd_ready, write_to_dmem, read_req_dmem, cmd_done, rdata_valid, pipe_stall}
            !== {idle, cur.wr, cur.rd, cur.done, cur.rv, !idle}
          || addr_dmem_host !== exp_addr || data_dmem_host !== exp_data
          || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL model t=%0t got rdy/wr/rd/done/rv/stall=%b%b%b%b%b%b addr=%h data=%h rdata=%h exp=%b%b%b%b%b%b addr=%h data=%h rdata=%h",
                 $time, cmd_ready, write_to_dmem, read_req_dmem, cmd_done, rdata_valid, pipe_stall,
                 addr_dmem_host, data_dmem_host, rdata,
                 idle, cur.wr, cur.rd, cur.done, cur.rv, !idle, exp_addr, exp_data, exp_rdata);
      end
    end
    if (!rst_n) begin
      plan.delete();
      exp_addr  = '0;
      exp_data  = '0;
      exp_rdata = '0;
      armed     = 1'b1;
    end else if (idle) begin
      if (cmd_valid) begin
        txn++;
        exp_addr = cmd_addr;
        exp_data = cmd_wdata;
        if (cmd_write) begin
          model_mem[cmd_addr]     = cmd_wdata;
          model_written[cmd_addr] = 1'b1;
          plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
          plan.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
          $display("txn %0d t=%0t write addr=%h data=%h", txn, $time, cmd_addr, cmd_wdata);
        end else begin
          pend_rdata = {32'h0, model_written[cmd_addr] ? model_mem[cmd_addr] : init_word(cmd_addr)};
          for (int i = 0; i < LAT; i++) plan.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
          plan.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
          $display("txn %0d t=%0t read  addr=%h expect=%h", txn, $time, cmd_addr, pend_rdata);
        end
      end
    end else begin
      if (plan.size() == 2 && plan[0].rd) exp_rdata = pend_rdata;
      void'(plan.pop_front());
    end
  end

  // One host command with explicit expectations on strobes, latency and read data.
  task automatic run_cmd(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input bit junk, input logic [63:0] exp_rd);
    int  lat, nwr, nrd;
    bit  got;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = cmd_ready;
    end
    chk("accept", 64'(got), 64'(1));
    @(posedge clk); #1;
    if (junk) begin
      cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
    end else begin
      cmd_valid = 1'b0;
    end
    lat = 0; nwr = 0; nrd = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(negedge clk);
      nwr += int'(write_to_dmem);
      nrd += int'(read_req_dmem);
      chk("hold_addr", 64'(addr_dmem_host), 64'(a));
      if (wr) chk("hold_data", 64'(data_dmem_host), 64'(d));
      if (cmd_done) begin
        lat = n;
      end else begin
        @(posedge clk); #1;
        if (junk) begin
          cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
        end
      end
    end
    chk("done_latency", 64'(lat), wr ? 64'(2) : 64'(LAT + 1));
    chk("rdata_valid", 64'(rdata_valid), 64'(!wr));
    chk("rdata", rdata, exp_rd);
    chk("wr_strobes", 64'(nwr), wr ? 64'(1) : 64'(0));
    chk("rd_strobes", 64'(nrd), wr ? 64'(0) : 64'(LAT));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    bit            junk;
    logic [63:0]   exp_rdata;
  } vec_t;

  vec_t vecs[9];
  int   acc, prev, gap_exp, pos, n_exp;
  bit   prevwr, w, got;

  initial begin
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 64'h0};
    vecs[1] = '{1'b0, 8'h10, 32'h0,        1'b0, 64'h00000000_DEADBEEF};
    vecs[2] = '{1'b1, 8'h22, 32'h12345678, 1'b1, 64'h00000000_DEADBEEF};
    vecs[3] = '{1'b0, 8'h22, 32'h0,        1'b1, 64'h00000000_12345678};
    vecs[4] = '{1'b1, 8'hFF, 32'hA5A5A5A5, 1'b0, 64'h00000000_12345678};
    vecs[5] = '{1'b0, 8'hFF, 32'h0,        1'b0, 64'h00000000_A5A5A5A5};
    vecs[6] = '{1'b0, 8'h10, 32'h0,        1'b1, 64'h00000000_DEADBEEF};
    vecs[7] = '{1'b1, 8'h00, 32'h00000001, 1'b1, 64'h00000000_DEADBEEF};
    vecs[8] = '{1'b0, 8'h00, 32'h0,        1'b0, 64'h00000000_00000001};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(cmd_ready), 64'(1));
    chk("reset_stall", 64'(pipe_stall), 64'(0));
    chk("reset_done", 64'({cmd_done, rdata_valid, write_to_dmem, read_req_dmem}), 64'(0));
    chk("reset_rdata", rdata, 64'h0);
    chk("reset_addr", 64'({addr_dmem_host, data_dmem_host}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].junk, vecs[i].exp_rdata);

    // cmd_valid held high with alternating direction
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = $urandom;
    acc = 0; prev = -1; prevwr = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("no_overlap", 64'(write_to_dmem & read_req_dmem), 64'(0));
      if (cmd_ready) begin
        if (prev >= 0) begin
          gap_exp = prevwr ? 3 : LAT + 2;
          chk("b2b_gap", 64'(c - prev), 64'(gap_exp));
        end
        prev = c; prevwr = cmd_write; acc++;
        @(posedge clk); #1;
        cmd_write = !cmd_write; cmd_addr = AW'($urandom_range(64, 79)); cmd_wdata = $urandom;
      end
    end
    n_exp = 0; pos = 0; w = 1'b1;
    while (pos < 20) begin
      n_exp++;
      pos += w ? 3 : LAT + 2;
      w = !w;
    end
    chk("b2b_count", 64'(acc), 64'(n_exp));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = cmd_ready;
    end
    chk("b2b_drain", 64'(got), 64'(1));

    // reset during the second RD cycle aborts the read
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h22;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = cmd_ready;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("abort_no_done", 64'({cmd_done, rdata_valid}), 64'(0));
      chk("abort_ready", 64'(cmd_ready), 64'(1));
      chk("abort_stall", 64'(pipe_stall), 64'(0));
      chk("abort_rdata", rdata, 64'h0);
    end
    run_cmd(1'b0, 8'h10, 32'h0, 1'b0, 64'h00000000_DEADBEEF);

    // READ_LAT=1 build
    @(posedge clk); #1;
    c1_valid = 1'b1; c1_write = 1'b0; c1_addr = 8'h05;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = c1_ready;
    end
    chk("lat1_accept", 64'(got), 64'(1));
    @(posedge clk); #1;
    c1_valid = 1'b0;
    acc = 0; prev = 0;
    for (int n = 1; n <= 6 && prev == 0; n++) begin
      @(negedge clk);
      acc += int'(c1_rd);
      if (c1_rv) prev = n;
    end
    chk("lat1_rd_strobes", 64'(acc), 64'(1));
    chk("lat1_rv_latency", 64'(prev), 64'(2));
    chk("lat1_rdata", c1_rdata, 64'h00000000_CAFE0005);

    // randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom_range(0, 99) != 0);
      cmd_valid = ($urandom_range(0, 9) < 7);
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom_range(0, 31));
      cmd_wdata = $urandom;
    end
    @(posedge clk); #1;
    rst_n = 1'b1; cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog t=%0t got=no_finish exp=finish", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
